// File: rtl/hh_gate_sequencer_if.sv
// Handshake bundle between hh_gate_sequencer and the shared gating-update unit.
//   upd_valid/upd_ready : request handshake (sequencer -> update unit)
//   upd_sel             : gate selector, 0=m, 1=h, 2=n
//   upd_x               : old value of the selected gate (x1000 fixed point)
//   upd_V / upd_dt      : membrane potential and time step for this step
//   resp_valid/resp_x   : returned next value of the gate (update unit -> sequencer)
interface hh_gate_sequencer_if;
  logic               upd_valid;
  logic               upd_ready;
  logic        [1:0]  upd_sel;
  logic signed [15:0] upd_x;
  logic signed [15:0] upd_V;
  logic        [15:0] upd_dt;
  logic               resp_valid;
  logic signed [15:0] resp_x;

  // Sequencer side
  modport master (
    output upd_valid, upd_sel, upd_x, upd_V, upd_dt,
    input  upd_ready, resp_valid, resp_x
  );

  // Shared update-unit side
  modport slave (
    input  upd_valid, upd_sel, upd_x, upd_V, upd_dt,
    output upd_ready, resp_valid, resp_x
  );
endinterface

// File: rtl/hh_gate_sequencer.sv
// Time-multiplexes one shared HH gating-update unit across gates m, h and n.
// One step per accepted start: each gate is issued in turn with its old value,
// results are clamped to [0,1000] into shadow registers and all three are
// committed on the same edge, so every gate of a step sees the same old state.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, V, dt        : step request; V/dt latched when the request is accepted
//   upd (master)        : request/response bundle to the shared update unit
//   m_out/h_out/n_out   : committed gate values (x1000)
//   busy                : not idle
//   done, err, clamp    : one-cycle end-of-step pulse, timeout abort, clamp seen
//   step_count          : committed steps, wraps modulo 2^16
module hh_gate_sequencer #(
  parameter int          M_INIT  = 53,
  parameter int          H_INIT  = 600,
  parameter int          N_INIT  = 318,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [15:0]    V,
  input  logic        [15:0]    dt,
  hh_gate_sequencer_if.master   upd,
  output logic signed [15:0]    m_out,
  output logic signed [15:0]    h_out,
  output logic signed [15:0]    n_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  clamp,
  output logic        [15:0]    step_count
);

  localparam int unsigned W = 16;
  localparam logic signed [W-1:0] M_RST    = W'(M_INIT);
  localparam logic signed [W-1:0] H_RST    = W'(H_INIT);
  localparam logic signed [W-1:0] N_RST    = W'(N_INIT);
  localparam logic signed [W-1:0] X_MIN    = 16'sd0;
  localparam logic signed [W-1:0] X_MAX    = 16'sd1000;
  // Last WAIT count before abort: the TIMEOUT-th empty WAIT cycle aborts
  localparam logic        [W-1:0] TMO_LAST = W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic        [1:0]   g_q, g_nxt;
  logic        [W-1:0] tmo_q, tmo_nxt;
  logic signed [W-1:0] v_q, v_nxt;
  logic        [W-1:0] dt_q, dt_nxt;
  logic signed [W-1:0] sh_m_q, sh_m_nxt;
  logic signed [W-1:0] sh_h_q, sh_h_nxt;
  logic                clamp_acc_q, clamp_acc_nxt;

  logic signed [W-1:0] m_nxt, h_nxt, n_nxt;
  logic        [W-1:0] step_nxt;
  logic                busy_nxt, done_nxt, err_nxt, clamp_nxt;
  logic                upd_valid_nxt;
  logic signed [W-1:0] upd_x_nxt;

  logic signed [W-1:0] resp_clamped;
  logic                resp_altered;
  logic                last_gate;
  logic                tmo_hit;

  assign last_gate = (g_q == 2'd2);
  assign tmo_hit   = !upd.resp_valid && (tmo_q == TMO_LAST);

  assign upd.upd_sel = g_q;
  assign upd.upd_V   = v_q;
  assign upd.upd_dt  = dt_q;

  // Saturate the returned gate value to the legal probability range
  always_comb begin
    resp_clamped = upd.resp_x;
    resp_altered = 1'b0;
    if (upd.resp_x < X_MIN) begin
      resp_clamped = X_MIN;
      resp_altered = 1'b1;
    end else if (upd.resp_x > X_MAX) begin
      resp_clamped = X_MAX;
      resp_altered = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (upd.upd_valid && upd.upd_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (upd.resp_valid) begin
          state_nxt = last_gate ? S_IDLE : S_ISSUE;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    g_nxt         = g_q;
    tmo_nxt       = tmo_q;
    v_nxt         = v_q;
    dt_nxt        = dt_q;
    sh_m_nxt      = sh_m_q;
    sh_h_nxt      = sh_h_q;
    clamp_acc_nxt = clamp_acc_q;
    m_nxt         = m_out;
    h_nxt         = h_out;
    n_nxt         = n_out;
    step_nxt      = step_count;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    clamp_nxt     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          v_nxt         = V;
          dt_nxt        = dt;
          g_nxt         = 2'd0;
          clamp_acc_nxt = 1'b0;
        end
      end
      S_ISSUE: begin
        if (upd.upd_valid && upd.upd_ready) tmo_nxt = '0;
      end
      S_WAIT: begin
        if (upd.resp_valid) begin
          clamp_acc_nxt = clamp_acc_q | resp_altered;
          if (g_q == 2'd0) sh_m_nxt = resp_clamped;
          if (g_q == 2'd1) sh_h_nxt = resp_clamped;
          if (last_gate) begin
            // n goes straight from the response; m/h from their shadows
            m_nxt     = sh_m_q;
            h_nxt     = sh_h_q;
            n_nxt     = resp_clamped;
            step_nxt  = step_count + 16'd1;
            done_nxt  = 1'b1;
            clamp_nxt = clamp_acc_q | resp_altered;
            g_nxt     = 2'd0;
          end else begin
            g_nxt = g_q + 2'd1;
          end
        end else if (tmo_hit) begin
          done_nxt = 1'b1;
          err_nxt  = 1'b1;
          g_nxt    = 2'd0;
        end else begin
          tmo_nxt = tmo_q + 16'd1;
        end
      end
      default: ;
    endcase

    upd_valid_nxt = (state_nxt == S_ISSUE);
    busy_nxt      = (state_nxt != S_IDLE);

    // Old value of the gate that will be presented next cycle
    unique case (g_nxt)
      2'd1:    upd_x_nxt = h_nxt;
      2'd2:    upd_x_nxt = n_nxt;
      default: upd_x_nxt = m_nxt;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q           <= 2'd0;
      tmo_q         <= '0;
      v_q           <= '0;
      dt_q          <= '0;
      sh_m_q        <= '0;
      sh_h_q        <= '0;
      clamp_acc_q   <= 1'b0;
      m_out         <= M_RST;
      h_out         <= H_RST;
      n_out         <= N_RST;
      step_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      clamp         <= 1'b0;
      upd.upd_valid <= 1'b0;
      upd.upd_x     <= M_RST;
    end else begin
      g_q           <= g_nxt;
      tmo_q         <= tmo_nxt;
      v_q           <= v_nxt;
      dt_q          <= dt_nxt;
      sh_m_q        <= sh_m_nxt;
      sh_h_q        <= sh_h_nxt;
      clamp_acc_q   <= clamp_acc_nxt;
      m_out         <= m_nxt;
      h_out         <= h_nxt;
      n_out         <= n_nxt;
      step_count    <= step_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      clamp         <= clamp_nxt;
      upd.upd_valid <= upd_valid_nxt;
      upd.upd_x     <= upd_x_nxt;
    end
  end

endmodule
